icache_refill: RTL and testbench
================================

# icache_refill

Refill controller for the instruction cache register array. It checks the fetch address against the tag and valid bit read out of the array and reports a hit. On a miss it fetches the whole block from memory, one 32-bit word per beat, assembles it, and writes block, tag and line index back into the array with a single-cycle `write_in` pulse. It sits between the fetch stage, the cache register array and the memory/bus port.

## Interface
- `offset_width`, 2: log2 of instructions per block; `block_size = 1 << offset_width`.
- `line_width`, 6: log2 of cache lines; `tag_width = 32 - offset_width - line_width - 2` (derived, not overridable).

- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `fetch_valid` in 1: fetch stage presents `address` this cycle.
- `address` in 32: fetch byte address.
- `tag` in tag_width: tag read from the array for `address`'s line.
- `tag_valid` in 1: valid bit read from the array for that line.
- `hit` out 1: `address` hits and may be consumed this cycle.
- `mem_req_valid` out 1: block read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: block-aligned address; low `offset_width+2` bits are zero.
- `mem_resp_valid` in 1: one response word this cycle. There is no backpressure.
- `mem_resp_data` in 32: response word. Words arrive in order, word 0 first.
- `write_in` out 1: array write strobe.
- `write_line_index` out line_width: line to write.
- `write_block` out 32*block_size: word j at bits [32*(j+1)-1 : 32*j].
- `write_tag` out tag_width: tag to write.

## Operation
- Field split of `address`: tag = [31 : line_width+offset_width+2], line = [line_width+offset_width+1 : offset_width+2], word = [offset_width+1 : 2].
- `hit` is combinational: `fetch_valid && state==IDLE && tag_valid && tag == address tag field`.
- FSM states:
  - IDLE: if `fetch_valid && !hit`, latch `address` and go to REQ.
  - REQ: `mem_req_valid=1` and `mem_req_addr` held stable until `mem_req_ready`. On the handshake, clear the beat counter and go to FILL.
  - FILL: each `mem_resp_valid` stores `mem_resp_data` into word slot `beat` and increments `beat` (offset_width bits). The beat at `beat == block_size-1` moves the FSM to WRITE. Gaps between beats are allowed.
  - WRITE: `write_in=1` for exactly one cycle, then IDLE.
- `write_line_index` and `write_tag` come from the latched address, never from live `address`. Changes on `address`/`fetch_valid` outside IDLE are ignored.
- `mem_resp_valid` outside FILL is ignored.
- `hit` is 0 in every non-IDLE state, regardless of the array outputs.
- One outstanding request at most.
- Reset, including mid-REQ or mid-FILL: state=IDLE, beat=0, `mem_req_valid=0`, `write_in=0`, and `write_block`, `write_tag`, `write_line_index`, `mem_req_addr` all 0. A partial block is discarded. The memory side drops any in-flight response.

## Timing
- Miss detected in cycle 0 (IDLE). `mem_req_valid` rises in cycle 1.
- Handshake in cycle k: FILL starts in cycle k+1. The first beat may arrive in cycle k+1.
- Last beat in cycle m: `write_in=1` in cycle m+1, IDLE in cycle m+2. The array holds the new line from edge m+2, so the re-presented fetch hits in cycle m+2.
- Minimum miss penalty with `ready` and back-to-back beats: block_size + 3 cycles.
- `write_block`, `write_tag` and `write_line_index` are registered and stable throughout WRITE.

## Structure
- Package `icache_pkg`:
  - state enum {IDLE, REQ, FILL, WRITE};
  - `tag_width`, `block_size` and field-position constants as functions of `offset_width`/`line_width`, shared with the array.
- Sub-module `icache_fill_buffer`:
  - beat counter plus word-indexed block register;
  - inputs `clear`, `beat_valid`, `beat_data`;
  - outputs `block`, `last`.
- Top level holds the FSM, the address latch and hit compare.

## Test plan
(Defaults: tag_width=22. Address 0x0000_1234 → line 0x23, word 1, tag 0x4.)
- Cold miss: reset, `fetch_valid=1`, `address=0x1234`, `tag_valid=0` → `hit=0`; next cycle `mem_req_valid=1`, `mem_req_addr=0x1230`, held through 3 cycles of `ready=0`. Beats 0xA0, 0xA1, 0xA2, 0xA3 → one-cycle `write_in` with `write_block={A3,A2,A1,A0}`, `write_line_index=0x23`, `write_tag=0x4`.
- Hit: IDLE, `address=0x1234`, `tag=0x4`, `tag_valid=1` → `hit=1` same cycle; no request ever issued.
- Tag mismatch: `tag=0x5`, `tag_valid=1` → `hit=0`, request to 0x1230.
- Gapped response: beats spaced 0, 2 and 5 idle cycles apart → `write_in` exactly one cycle after the 4th beat; spurious `mem_resp_valid` in IDLE/REQ leaves `write_block` unchanged.
- Address change mid-miss: `address` switches to 0x8000 during FILL → `write_tag=0x4`, `write_line_index=0x23`; `hit=0` throughout.
- Reset mid-FILL after 2 beats → all outputs 0 asynchronously; no `write_in`. The same fetch after release reissues the request to 0x1230.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding and address field geometry for the
// instruction cache refill controller and the cache register array.
`default_nettype none

package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam int OFFSET_WIDTH_DEF = 2;
    localparam int LINE_WIDTH_DEF   = 6;

    function automatic int tag_width_f(input int ow, input int lw);
        return 32 - ow - lw - 2;
    endfunction

    function automatic int block_size_f(input int ow);
        return 1 << ow;
    endfunction

    // Lowest bit of each address field; the word field always starts at bit 2.
    function automatic int word_lsb_f();
        return 2;
    endfunction

    function automatic int line_lsb_f(input int ow);
        return ow + 2;
    endfunction

    function automatic int tag_lsb_f(input int ow, input int lw);
        return lw + ow + 2;
    endfunction

    localparam int TAG_WIDTH_DEF  = tag_width_f(OFFSET_WIDTH_DEF, LINE_WIDTH_DEF);
    localparam int BLOCK_SIZE_DEF = block_size_f(OFFSET_WIDTH_DEF);

endpackage

`default_nettype wire

// File: rtl/icache_fill_buffer.sv
// icache_fill_buffer: beat counter and word-indexed block register that
// assembles one cache block from in-order memory response words.
`default_nettype none

module icache_fill_buffer
    import icache_pkg::*;
#(
    parameter  int offset_width = 2,
    localparam int block_size   = block_size_f(offset_width)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      beat_valid,
    input  logic [31:0]               beat_data,
    output logic [32*block_size-1:0]  block,
    output logic                      last
);

    logic [offset_width-1:0]  r_beat;
    logic [32*block_size-1:0] r_block;

    // The block is not wiped on clear: stale words are always overwritten
    // before the block is ever written to the array.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_beat  <= '0;
            r_block <= '0;
        end else if (clear) begin
            r_beat  <= '0;
        end else if (beat_valid) begin
            r_beat                  <= r_beat + 1'b1;
            r_block[32*r_beat +: 32] <= beat_data;
        end
    end

    assign block = r_block;
    assign last  = &r_beat;

endmodule

`default_nettype wire

// File: rtl/icache_refill.sv
// icache_refill: hit detection against the cache array and block refill
// from memory on a miss, finished by a single-cycle array write.
`default_nettype none

module icache_refill
    import icache_pkg::*;
#(
    parameter  int offset_width = 2,
    parameter  int line_width   = 6,
    localparam int tag_width    = tag_width_f(offset_width, line_width),
    localparam int block_size   = block_size_f(offset_width)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fetch_valid,
    input  logic [31:0]               address,
    input  logic [tag_width-1:0]      tag,
    input  logic                      tag_valid,
    output logic                      hit,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [31:0]               mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic                      write_in,
    output logic [line_width-1:0]     write_line_index,
    output logic [32*block_size-1:0]  write_block,
    output logic [tag_width-1:0]      write_tag
);

    localparam int c_LINE_LSB = line_lsb_f(offset_width);
    localparam int c_TAG_LSB  = tag_lsb_f(offset_width, line_width);

    state_e                r_state;
    logic [31:c_LINE_LSB]  r_addr;

    logic w_hit;
    logic w_clear;
    logic w_beat_valid;
    logic w_last;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = ^address[c_LINE_LSB-1:0];

    assign w_hit        = fetch_valid && (r_state == IDLE) && tag_valid &&
                          (tag == address[31:c_TAG_LSB]);
    assign w_clear      = (r_state == REQ) && mem_req_ready;
    assign w_beat_valid = (r_state == FILL) && mem_resp_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_valid && !w_hit) begin
                        r_addr  <= address[31:c_LINE_LSB];
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) r_state <= FILL;
                end
                FILL: begin
                    if (w_beat_valid && w_last) r_state <= WRITE;
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    icache_fill_buffer #(
        .offset_width (offset_width)
    ) u_fill_buffer (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_clear),
        .beat_valid (w_beat_valid),
        .beat_data  (mem_resp_data),
        .block      (write_block),
        .last       (w_last)
    );

    assign hit              = w_hit;
    assign mem_req_valid    = (r_state == REQ);
    assign mem_req_addr     = {r_addr, {(offset_width+2){1'b0}}};
    assign write_in         = (r_state == WRITE);
    assign write_line_index = r_addr[c_TAG_LSB-1:c_LINE_LSB];
    assign write_tag        = r_addr[31:c_TAG_LSB];

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed scenarios for the refill controller with
// hand-computed expectations at the default geometry (tag 22b, 4 words).
`default_nettype none

module tb_icache_refill;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         fetch_valid = 1'b0;
    logic [31:0]  address = '0;
    logic [21:0]  tag = '0;
    logic         tag_valid = 1'b0;
    logic         hit;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [31:0]  mem_resp_data = '0;
    logic         write_in;
    logic [5:0]   write_line_index;
    logic [127:0] write_block;
    logic [21:0]  write_tag;

    int checks = 0;
    int errors = 0;

    icache_refill dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .address          (address),
        .tag              (tag),
        .tag_valid        (tag_valid),
        .hit              (hit),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .write_in         (write_in),
        .write_line_index (write_line_index),
        .write_block      (write_block),
        .write_tag        (write_tag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] blk(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Drives four beats (gap before beat 0 is zero) and checks the write cycle.
    task automatic run_fill(input int g1, input int g2, input int g3,
                            input logic [31:0] base, input string name);
        int gaps[4];
        gaps = '{0, g1, g2, g3};
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                mem_resp_valid = 1'b0;
                #1;
                checks++;
                if (write_in !== 1'b0 || hit !== 1'b0) begin
                    errors++;
                    $display("FAIL %s gap: write_in=%b hit=%b expected 0 0", name, write_in, hit);
                end
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(i);
            #1;
            checks++;
            if (write_in !== 1'b0 || hit !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d: write_in=%b hit=%b expected 0 0", name, i, write_in, hit);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (write_in !== 1'b1) begin
            errors++;
            $display("FAIL %s write_in: got %b expected 1", name, write_in);
        end
        checks++;
        if (write_block !== blk(base)) begin
            errors++;
            $display("FAIL %s write_block: got %h expected %h", name, write_block, blk(base));
        end
        checks++;
        if (write_tag !== 22'h4 || write_line_index !== 6'h23) begin
            errors++;
            $display("FAIL %s tag/line: got %h/%h expected 4/23", name, write_tag, write_line_index);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL %s write cycle req/hit: got %b/%b expected 0/0", name, mem_req_valid, hit);
        end
        tick();
        #1;
        checks++;
        if (write_in !== 1'b0) begin
            errors++;
            $display("FAIL %s write_in after: got %b expected 0", name, write_in);
        end
    endtask

    task automatic reset_dut();
        reset          = 1'b0;
        fetch_valid    = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        tag_valid      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (mem_req_valid !== 1'b0 || write_in !== 1'b0) begin
            errors++;
            $display("FAIL reset strobes: req=%b write_in=%b expected 0 0", mem_req_valid, write_in);
        end
        checks++;
        if (write_block !== 128'h0 || write_tag !== 22'h0 || write_line_index !== 6'h0 ||
            mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset data: blk=%h tag=%h line=%h addr=%h expected all 0",
                     write_block, write_tag, write_line_index, mem_req_addr);
        end
    endtask

    task automatic test_cold_miss();
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag         = 22'h0;
        tag_valid   = 1'b0;
        #1;
        checks++;
        if (hit !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss detect: hit=%b req=%b expected 0 0", hit, mem_req_valid);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1230) begin
                errors++;
                $display("FAIL cold_miss req hold%0d: valid=%b addr=%h expected 1 00001230",
                         c, mem_req_valid, mem_req_addr);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL cold_miss handshake: valid=%b expected 1", mem_req_valid);
        end
        tick();
        mem_req_ready = 1'b0;
        run_fill(0, 0, 0, 32'hA0, "cold_miss");
        tag       = 22'h4;
        tag_valid = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL cold_miss refetch hit: got %b expected 1", hit);
        end
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag         = 22'h4;
        tag_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hit !== 1'b1 || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hit cycle%0d: hit=%b req=%b expected 1 0", c, hit, mem_req_valid);
            end
            tick();
        end
        fetch_valid = 1'b0;
    endtask

    task automatic test_tag_mismatch();
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag         = 22'h5;
        tag_valid   = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL mismatch hit: got %b expected 0", hit);
        end
        tick();
        mem_req_ready = 1'b1;
        tag           = 22'h4;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1230 || hit !== 1'b0) begin
            errors++;
            $display("FAIL mismatch req: valid=%b addr=%h hit=%b expected 1 00001230 0",
                     mem_req_valid, mem_req_addr, hit);
        end
        tick();
        mem_req_ready = 1'b0;
        run_fill(0, 0, 0, 32'hB0, "mismatch");
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_gapped();
        fetch_valid    = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (write_block !== blk(32'hB0)) begin
            errors++;
            $display("FAIL gapped idle spurious: blk=%h expected %h", write_block, blk(32'hB0));
        end
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag_valid   = 1'b0;
        tick();
        tick();
        checks++;
        if (write_block !== blk(32'hB0) || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL gapped req spurious: blk=%h req=%b expected %h 1",
                     write_block, mem_req_valid, blk(32'hB0));
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        run_fill(0, 2, 5, 32'hC0, "gapped");
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag_valid   = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        address       = 32'h0000_8000;
        tag           = 22'h20;
        tag_valid     = 1'b1;
        run_fill(1, 0, 2, 32'h50, "addr_change");
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        fetch_valid = 1'b1;
        address     = 32'h0000_1234;
        tag_valid   = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hE0;
        tick();
        mem_resp_data  = 32'hE1;
        tick();
        mem_resp_valid = 1'b0;
        fetch_valid    = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || write_in !== 1'b0 || write_block !== 128'h0 ||
            write_tag !== 22'h0 || write_line_index !== 6'h0 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: req=%b wr=%b blk=%h tag=%h line=%h addr=%h expected all 0",
                     mem_req_valid, write_in, write_block, write_tag, write_line_index, mem_req_addr);
        end
        tick();
        tick();
        checks++;
        if (write_in !== 1'b0) begin
            errors++;
            $display("FAIL reset hold write_in: got %b expected 0", write_in);
        end
        reset       = 1'b1;
        fetch_valid = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset detect: hit=%b req=%b expected 0 0", hit, mem_req_valid);
        end
        tick();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1230) begin
            errors++;
            $display("FAIL post_reset reissue: valid=%b addr=%h expected 1 00001230",
                     mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        run_fill(0, 0, 0, 32'hF0, "post_reset");
        fetch_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_tag_mismatch();
        test_gapped();
        test_addr_change();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
